// File: rtl/irq_controller.sv
// Vectored interrupt controller: synchronises and edge-detects external
// request lines, latches them as pending, arbitrates by fixed priority
// (line 0 highest) and hands one vector at a time to the CPU control path.
// Non-nesting: a single handler may be in service.
module irq_controller #(
  parameter int              NIRQ     = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0,
  parameter int              VEC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [7:0]      cfg_wdata,
  output logic [7:0]      cfg_rdata,
  output logic            irq_req,
  output logic [PC_W-1:0] irq_vec,
  input  logic            irq_ack,
  input  logic            irq_ret,
  output logic            in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] sync_a_q, sync_b_q, prev_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic            gie_q, gie_d;
  logic [2:0]      win_idx_q, win_idx_d;
  logic [2:0]      active_idx_q, active_idx_d;
  logic [PC_W-1:0] irq_vec_q, irq_vec_d;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr_w1c;
  logic [NIRQ-1:0] clr_ack;
  logic [2:0]      winner;
  logic            ack_take;
  logic            unused_wdata;

  // Upper write-data bits have no register behind them when NIRQ < 8.
  assign unused_wdata = ^cfg_wdata;

  assign rise     = sync_b_q & ~prev_q;
  assign eligible = pend_q & mask_q;
  assign ack_take = (state_q == REQ) && irq_ack;
  assign clr_w1c  = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NIRQ-1:0] : '0;

  // Ack clears only the locked winner's pending bit.
  always_comb begin
    clr_ack = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr_ack[i] = ack_take && (win_idx_q == 3'(i));
    end
  end

  // Fixed-priority encoder: lowest-index eligible line wins.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Pending/config next state; a new rising edge beats any clear of the same bit.
  always_comb begin
    pend_d = (pend_q & ~clr_w1c & ~clr_ack) | rise;
    mask_d = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[NIRQ-1:0] : mask_q;
    gie_d  = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[0] : gie_q;
  end

  // Sequencing FSM: winner and vector are captured on entry to REQ and held.
  always_comb begin
    state_d      = state_q;
    win_idx_d    = win_idx_q;
    active_idx_d = active_idx_q;
    irq_vec_d    = irq_vec_q;
    case (state_q)
      IDLE: begin
        if (gie_q && (|eligible)) begin
          state_d   = REQ;
          win_idx_d = winner;
          irq_vec_d = VEC_BASE + PC_W'(winner) * PC_W'(VEC_STEP);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d      = SERVICE;
          active_idx_d = win_idx_q;
        end
      end
      SERVICE: begin
        if (irq_ret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, including the two-stage synchroniser and edge-detect flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_a_q     <= '0;
      sync_b_q     <= '0;
      prev_q       <= '0;
      pend_q       <= '0;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      win_idx_q    <= '0;
      active_idx_q <= '0;
      irq_vec_q    <= '0;
    end else begin
      state_q      <= state_d;
      sync_a_q     <= irq_in;
      sync_b_q     <= sync_a_q;
      prev_q       <= sync_b_q;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      win_idx_q    <= win_idx_d;
      active_idx_q <= active_idx_d;
      irq_vec_q    <= irq_vec_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_vec    = irq_vec_q;

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      2'd0:    cfg_rdata = 8'(mask_q);
      2'd1:    cfg_rdata = 8'(pend_q);
      2'd2:    cfg_rdata = {gie_q, 3'b000, in_service, active_idx_q};
      default: cfg_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller: each scenario task drives stimulus
// and checks against hand-computed values.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic       irq_req;
  logic [9:0] irq_vec;
  logic       irq_ack = 1'b0;
  logic       irq_ret = 1'b0;
  logic       in_service;

  int compared = 0;
  int mismatched = 0;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // One-cycle pulse: the request lines are sampled high at exactly one edge.
  task automatic pulse(input logic [3:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b want 0", irq_req); end
    compared++; if (irq_vec !== 10'h000) begin mismatched++; $display("FAIL reset_vec: got %h want 000", irq_vec); end
    compared++; if (in_service !== 1'b0) begin mismatched++; $display("FAIL reset_insvc: got %b want 0", in_service); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = a[1:0]; #1;
      compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL reset_reg%0d: got %h want 00", a, cfg_rdata); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    cfg_write(2'd0, 8'h0F);
    cfg_write(2'd2, 8'h01);
    pulse(4'b0100);                 // edge k
    tick();                         // edge k+1
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL single_pend_k1: got %h want 00", cfg_rdata); end
    tick();                         // edge k+2
    compared++; if (cfg_rdata !== 8'h04) begin mismatched++; $display("FAIL single_pend_k2: got %h want 04", cfg_rdata); end
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL single_req_k2: got %b want 0", irq_req); end
    tick();                         // edge k+3
    compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL single_req_k3: got %b want 1", irq_req); end
    compared++; if (irq_vec !== 10'h3F8) begin mismatched++; $display("FAIL single_vec: got %h want 3F8", irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    compared++; if (in_service !== 1'b1) begin mismatched++; $display("FAIL single_insvc: got %b want 1", in_service); end
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL single_req_ack: got %b want 0", irq_req); end
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL single_pend_ack: got %h want 00", cfg_rdata); end
    cfg_addr = 2'd2; #1;
    compared++; if (cfg_rdata !== 8'h8A) begin mismatched++; $display("FAIL single_ctrl_svc: got %h want 8A", cfg_rdata); end
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    compared++; if (in_service !== 1'b0) begin mismatched++; $display("FAIL single_insvc_ret: got %b want 0", in_service); end
    cfg_addr = 2'd2; #1;
    compared++; if (cfg_rdata !== 8'h82) begin mismatched++; $display("FAIL single_ctrl_idle: got %h want 82", cfg_rdata); end
    $display("test_single done");
  endtask

  task automatic test_priority();
    pulse(4'b1010);
    tick(); tick(); tick();
    compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL prio_req: got %b want 1", irq_req); end
    compared++; if (irq_vec !== 10'h3F4) begin mismatched++; $display("FAIL prio_vec1: got %h want 3F4", irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h08) begin mismatched++; $display("FAIL prio_pend_ack: got %h want 08", cfg_rdata); end
    compared++; if (in_service !== 1'b1) begin mismatched++; $display("FAIL prio_insvc: got %b want 1", in_service); end
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL prio_req_ret1: got %b want 0", irq_req); end
    tick();
    compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL prio_req_ret2: got %b want 1", irq_req); end
    compared++; if (irq_vec !== 10'h3FC) begin mismatched++; $display("FAIL prio_vec3: got %h want 3FC", irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    $display("test_priority done");
  endtask

  task automatic test_locked();
    pulse(4'b0100);
    tick(); tick(); tick();
    compared++; if (irq_vec !== 10'h3F8) begin mismatched++; $display("FAIL lock_vec0: got %h want 3F8", irq_vec); end
    // Line 0 rises and software clears the winner's pending bit together.
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h04; irq_in = 4'b0001;
    tick();
    cfg_we = 1'b0; irq_in = '0;
    for (int c = 0; c < 3; c++) begin
      compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL lock_req%0d: got %b want 1", c, irq_req); end
      compared++; if (irq_vec !== 10'h3F8) begin mismatched++; $display("FAIL lock_vec%0d: got %h want 3F8", c, irq_vec); end
      if (c < 2) tick();
    end
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h01) begin mismatched++; $display("FAIL lock_pend: got %h want 01", cfg_rdata); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    cfg_addr = 2'd2; #1;
    compared++; if (cfg_rdata !== 8'h8A) begin mismatched++; $display("FAIL lock_ctrl: got %h want 8A", cfg_rdata); end
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    tick();
    compared++; if (irq_vec !== 10'h3F0) begin mismatched++; $display("FAIL lock_next_vec: got %h want 3F0", irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    $display("test_locked done");
  endtask

  task automatic test_mask();
    cfg_write(2'd0, 8'h00);
    pulse(4'b1011);
    tick(); tick(); tick(); tick();
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL mask_req0: got %b want 0", irq_req); end
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h0B) begin mismatched++; $display("FAIL mask_pend: got %h want 0B", cfg_rdata); end
    cfg_addr = 2'd0; #1;
    compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL mask_read: got %h want 00", cfg_rdata); end
    cfg_write(2'd0, 8'h01);
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL mask_req_wr: got %b want 0", irq_req); end
    tick();
    compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL mask_req_on: got %b want 1", irq_req); end
    compared++; if (irq_vec !== 10'h3F0) begin mismatched++; $display("FAIL mask_vec: got %h want 3F0", irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    cfg_write(2'd2, 8'h00);
    cfg_write(2'd0, 8'h0F);
    tick(); tick();
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL gie_off_req: got %b want 0", irq_req); end
    cfg_addr = 2'd2; #1;
    compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL gie_off_ctrl: got %h want 00", cfg_rdata); end
    cfg_write(2'd1, 8'h0F);
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL w1c_pend: got %h want 00", cfg_rdata); end
    cfg_write(2'd2, 8'h01);
    $display("test_mask done");
  endtask

  task automatic test_back_to_back();
    pulse(4'b0010);
    tick(); tick(); tick();
    compared++; if (irq_vec !== 10'h3F4) begin mismatched++; $display("FAIL b2b_vec: got %h want 3F4", irq_vec); end
    irq_in = 4'b0010; irq_ret = 1'b1;
    tick();                          // edge m: ret ignored in REQ
    irq_in = '0; irq_ret = 1'b0;
    compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL b2b_ret_in_req: got %b want 1", irq_req); end
    compared++; if (in_service !== 1'b0) begin mismatched++; $display("FAIL b2b_ret_insvc: got %b want 0", in_service); end
    tick();                          // edge m+1: rise visible this cycle
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h02) begin mismatched++; $display("FAIL b2b_pend_kept: got %h want 02", cfg_rdata); end
    compared++; if (in_service !== 1'b1) begin mismatched++; $display("FAIL b2b_insvc: got %b want 1", in_service); end
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    tick();
    compared++; if (irq_req !== 1'b1) begin mismatched++; $display("FAIL b2b_rereq: got %b want 1", irq_req); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;   // ack while IDLE
    compared++; if (in_service !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_ack_insvc: got %b want 0", in_service); end
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_ack_req: got %b want 0", irq_req); end
    cfg_addr = 2'd2; #1;
    compared++; if (cfg_rdata !== 8'h81) begin mismatched++; $display("FAIL b2b_idle_ctrl: got %h want 81", cfg_rdata); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_service();
    pulse(4'b1000);
    tick(); tick(); tick();
    compared++; if (irq_vec !== 10'h3FC) begin mismatched++; $display("FAIL rsvc_vec: got %h want 3FC", irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    pulse(4'b0001);
    tick(); tick();
    cfg_addr = 2'd1; #1;
    compared++; if (cfg_rdata !== 8'h01) begin mismatched++; $display("FAIL rsvc_pend: got %h want 01", cfg_rdata); end
    compared++; if (in_service !== 1'b1) begin mismatched++; $display("FAIL rsvc_insvc_pre: got %b want 1", in_service); end
    reset = 1'b1; tick(); reset = 1'b0;
    compared++; if (in_service !== 1'b0) begin mismatched++; $display("FAIL rsvc_insvc: got %b want 0", in_service); end
    compared++; if (irq_req !== 1'b0) begin mismatched++; $display("FAIL rsvc_req: got %b want 0", irq_req); end
    compared++; if (irq_vec !== 10'h000) begin mismatched++; $display("FAIL rsvc_vec0: got %h want 000", irq_vec); end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = a[1:0]; #1;
      compared++; if (cfg_rdata !== 8'h00) begin mismatched++; $display("FAIL rsvc_reg%0d: got %h want 00", a, cfg_rdata); end
    end
    $display("test_reset_service done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_locked();
    test_mask();
    test_back_to_back();
    test_reset_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
